beep_scheduler: RTL



---
 rtl/beep_scheduler_if.sv | 35 +++
 rtl/beep_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/beep_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : beep_scheduler_if
//  Purpose  : Request/grant bundle between the answering-machine prompt
//             channels and the shared buzzer scheduler.
//  Signals  : req/count   - per-channel request level and pulse count
//             grant       - one-hot owner, busy/done/aborted - status
//             beep        - buzzer drive
//  Revision : 1.0 - initial release
// ============================================================================
interface beep_scheduler_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 4
);
   logic [NCH-1:0]       req;
   logic [NCH*CNT_W-1:0] count;
   logic [NCH-1:0]       grant;
   logic                 busy;
   logic                 done;
   logic                 aborted;
   logic                 beep;

   // Requesting side
   modport master (
      output req, count,
      input  grant, busy, done, aborted, beep
   );

   // Scheduler side
   modport slave (
      input  req, count,
      output grant, busy, done, aborted, beep
   );
endinterface
`default_nettype wire

// File: rtl/beep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : beep_scheduler
//  Purpose  : Round-robin arbiter sharing one buzzer among NCH channels.
//             A granted channel plays n tone pulses (ON_CYC cycles each,
//             beep toggling) separated by OFF_CYC silent cycles, followed
//             by a one-cycle done pulse. Dropping req mid-burst aborts.
//  Ports    : clkout  - tone-rate clock (rising edge)
//             rst_n   - asynchronous active-low reset
//             bus     - beep_scheduler_if.slave (req, count, grant, busy,
//                       done, aborted, beep); all outputs registered
//  Revision : 1.0 - initial release
// ============================================================================
module beep_scheduler #(
   parameter int NCH     = 4,
   parameter int CNT_W   = 4,
   parameter int ON_CYC  = 1000,
   parameter int OFF_CYC = 1000
) (
   input  wire                 clkout,
   input  wire                 rst_n,
   beep_scheduler_if.slave     bus
);
   localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int TCNT_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int LAST_W  = $clog2(NCH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NCH-1:0]      grant_q, grant_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    pcnt_q, pcnt_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [LAST_W-1:0]   last_q, last_d;
   logic                beep_q, beep_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;

   logic [LAST_W-1:0]   winner;
   logic                found;
   logic [CNT_W-1:0]    win_cnt;
   logic                owner_req;

   // Circular search starting one past the previous owner, so a channel
   // that was just served has the lowest priority.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         int idx;
         idx = (int'(last_q) + i) % NCH;
         if (!found && bus.req[idx]) begin
            found  = 1'b1;
            winner = LAST_W'(idx);
         end
      end
   end

   assign win_cnt   = bus.count[int'(winner)*CNT_W +: CNT_W];
   // last_q holds the current owner for the whole burst.
   assign owner_req = bus.req[last_q];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      n_d       = n_q;
      pcnt_d    = pcnt_q;
      tcnt_d    = tcnt_q;
      last_d    = last_q;
      beep_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = NCH'(1) << winner;
               n_d     = win_cnt;
               pcnt_d  = '0;
               tcnt_d  = '0;
               last_d  = winner;
               if (win_cnt == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ON;
               end
            end
         end
         S_ON: begin
            if (!owner_req) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (tcnt_q == TCNT_W'(ON_CYC - 1)) begin
               tcnt_d = '0;
               pcnt_d = pcnt_q + CNT_W'(1);
               if ((pcnt_q + CNT_W'(1)) == n_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_OFF;
               end
            end else begin
               beep_d = ~beep_q;
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         S_OFF: begin
            if (!owner_req) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               aborted_d = 1'b1;
            end else if (tcnt_q == TCNT_W'(OFF_CYC - 1)) begin
               tcnt_d  = '0;
               state_d = S_ON;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         n_q       <= '0;
         pcnt_q    <= '0;
         tcnt_q    <= '0;
         last_q    <= LAST_W'(NCH - 1);
         beep_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         n_q       <= n_d;
         pcnt_q    <= pcnt_d;
         tcnt_q    <= tcnt_d;
         last_q    <= last_d;
         beep_q    <= beep_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;
   assign bus.beep    = beep_q;

endmodule
`default_nettype wire
